// File: rtl/manchester_decoder.sv
// manchester_decoder: recovers data bits from a Manchester line (first half = data,
// second half = ~data), framed by an idle-low line and a leading sync bit of 1.
// Ports: clk, rst (async, active high), in_line (async raw line);
//        out_data/out_clk (decoded bit + 1-cycle strobe), out_error (1-cycle pulse),
//        out_pulsewidth (measured bit period 2*H), out_busy (inside a frame).
module manchester_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HALF    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_line,
    output logic       out_data,
    output logic       out_clk,
    output logic       out_error,
    output logic [5:0] out_pulsewidth,
    output logic       out_busy
);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        BIT
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [6:0]             cnt;
    logic [4:0]             h;
    logic                   bound_seen;

    logic       lvl;
    logic       edge_seen;
    logic       rise;
    logic       fall;
    logic [6:0] lo;
    logic [6:0] mid;
    logic [6:0] hi;
    logic       is_glitch;
    logic       is_mid;
    logic       timeout;
    logic       keep_cnt;

    assign lvl       = sync_q[SYNC_STAGES-1];
    assign edge_seen = lvl ^ hist_q;
    assign rise      = edge_seen & lvl;
    assign fall      = edge_seen & ~lvl;

    assign lo  = {3'b000, h[4:1]};
    assign mid = {2'b00, h} + lo;
    assign hi  = {1'b0, h, 1'b0} + lo;

    assign is_glitch = cnt < lo;
    assign is_mid    = (cnt >= mid) && (cnt <= hi);
    assign timeout   = cnt > hi;

    // Inside a bit the count must run from the previous mid-bit edge,
    // so an accepted boundary edge leaves the counter alone.
    assign keep_cnt = (state == BIT) && !timeout && !is_glitch && !is_mid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            sync_q         <= '0;
            hist_q         <= 1'b0;
            cnt            <= 7'd0;
            h              <= 5'd0;
            bound_seen     <= 1'b0;
            out_data       <= 1'b0;
            out_clk        <= 1'b0;
            out_error      <= 1'b0;
            out_pulsewidth <= 6'd0;
            out_busy       <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], in_line};
            hist_q    <= lvl;
            out_clk   <= 1'b0;
            out_error <= 1'b0;

            // Loaded with 1 so that c equals the edge-to-edge spacing in cycles.
            if (edge_seen && !keep_cnt) begin
                cnt <= 7'd1;
            end else if (cnt != 7'd127) begin
                cnt <= cnt + 7'd1;
            end

            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= SYNC;
                        out_busy <= 1'b1;
                    end
                end
                SYNC: begin
                    if (fall && cnt >= 7'(MIN_HALF) && cnt <= 7'd31) begin
                        h              <= cnt[4:0];
                        out_pulsewidth <= {cnt[4:0], 1'b0};
                        bound_seen     <= 1'b0;
                        state          <= BIT;
                    end else if (fall || cnt >= 7'd32) begin
                        out_error <= 1'b1;
                        out_busy  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                BIT: begin
                    if (timeout) begin
                        // End of frame; a coincident edge is dropped.
                        out_busy <= 1'b0;
                        state    <= IDLE;
                    end else if (edge_seen) begin
                        if (is_glitch || (!is_mid && bound_seen)) begin
                            out_error <= 1'b1;
                            out_busy  <= 1'b0;
                            state     <= IDLE;
                        end else if (is_mid) begin
                            out_data   <= ~lvl;
                            out_clk    <= 1'b1;
                            bound_seen <= 1'b0;
                        end else begin
                            bound_seen <= 1'b1;
                        end
                    end
                end
                default: begin
                    out_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_manchester_decoder.sv
// tb_manchester_decoder: directed Manchester frames into manchester_decoder,
// checking decoded bits, strobes, errors, pulse width and busy.
module tb_manchester_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_line;
    logic       out_data;
    logic       out_clk;
    logic       out_error;
    logic [5:0] out_pulsewidth;
    logic       out_busy;

    int   nvec  = 0;
    int   nmis  = 0;
    int   nclk  = 0;
    int   nerr  = 0;
    int   nboth = 0;
    logic dq[$];

    manchester_decoder #(
        .SYNC_STAGES(2),
        .MIN_HALF   (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_line       (in_line),
        .out_data      (out_data),
        .out_clk       (out_clk),
        .out_error     (out_error),
        .out_pulsewidth(out_pulsewidth),
        .out_busy      (out_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_clk) begin
            nclk++;
            dq.push_back(out_data);
        end
        if (out_error) nerr++;
        if (out_clk && out_error) nboth++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nmis++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic seg(input logic lvl, input int n);
        in_line = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int h, input int nb, input logic [7:0] bits, input int idle);
        seg(1'b1, h);
        seg(1'b0, h);
        for (int i = 0; i < nb; i++) begin
            seg(bits[i], h);
            seg(~bits[i], h);
        end
        seg(1'b0, idle);
    endtask

    task automatic clear_obs();
        nclk = 0;
        nerr = 0;
        dq.delete();
    endtask

    task automatic expect_run(input string tag, input int eclk, input logic [7:0] edata,
                              input int eerr, input logic [5:0] epw);
        logic [7:0] got;
        got = '0;
        for (int i = 0; i < dq.size() && i < 8; i++) got[i] = dq[i];
        chk({tag, "_nclk"}, nclk, eclk);
        chk({tag, "_data"}, got, edata);
        chk({tag, "_nerr"}, nerr, eerr);
        chk({tag, "_pw"}, out_pulsewidth, epw);
        chk({tag, "_busy"}, out_busy, 1'b0);
        clear_obs();
    endtask

    initial begin
        rst     = 1'b1;
        in_line = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", out_data, 1'b0);
        chk("rst_clk", out_clk, 1'b0);
        chk("rst_err", out_error, 1'b0);
        chk("rst_pw", out_pulsewidth, 6'd0);
        chk("rst_busy", out_busy, 1'b0);
        rst = 1'b0;
        seg(1'b0, 5);

        // H=10, bits 1,0,1,1 with exact strobe latency on the first bit
        seg(1'b1, 10);
        seg(1'b0, 10);
        seg(1'b1, 10);
        in_line = 1'b0;
        repeat (2) @(negedge clk);
        chk("lat_early", out_clk, 1'b0);
        @(negedge clk);
        chk("lat_clk", out_clk, 1'b1);
        chk("lat_data", out_data, 1'b1);
        @(negedge clk);
        chk("lat_pulse", out_clk, 1'b0);
        seg(1'b0, 6);
        seg(1'b0, 10);
        seg(1'b1, 10);
        seg(1'b1, 10);
        seg(1'b0, 10);
        seg(1'b1, 10);
        seg(1'b0, 20);
        chk("t1_busy_hold", out_busy, 1'b1);
        seg(1'b0, 15);
        expect_run("t1", 4, 8'b1101, 0, 6'd20);

        // 1-cycle sync pulse, then H=4 bit 0
        seg(1'b1, 1);
        seg(1'b0, 12);
        expect_run("t2a", 0, 8'b0, 1, 6'd20);
        send(4, 1, 8'b0, 20);
        expect_run("t2b", 1, 8'b0, 0, 6'd8);

        // glitch 3 cycles after a mid-bit edge
        seg(1'b1, 10);
        seg(1'b0, 10);
        seg(1'b1, 10);
        seg(1'b0, 3);
        seg(1'b1, 7);
        seg(1'b0, 30);
        expect_run("t3", 1, 8'b1, 1, 6'd20);

        // sync high too long
        seg(1'b1, 20);
        chk("t4a_busy", out_busy, 1'b1);
        seg(1'b1, 20);
        seg(1'b0, 20);
        expect_run("t4a", 0, 8'b0, 1, 6'd20);

        // H=31: mid-bit edge at c=77 decodes, edge at c=78 is dropped
        seg(1'b1, 31);
        seg(1'b0, 31);
        seg(1'b1, 46);
        seg(1'b0, 78);
        seg(1'b1, 10);
        seg(1'b0, 40);
        expect_run("t4b", 1, 8'b1, 0, 6'd62);

        // async reset 5 cycles into bit 2 of an H=8 frame
        seg(1'b1, 8);
        seg(1'b0, 8);
        seg(1'b1, 8);
        seg(1'b0, 8);
        seg(1'b0, 5);
        chk("t5_pre_busy", out_busy, 1'b1);
        chk("t5_pre_pw", out_pulsewidth, 6'd16);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", out_busy, 1'b0);
        chk("t5_rst_data", out_data, 1'b0);
        chk("t5_rst_pw", out_pulsewidth, 6'd0);
        chk("t5_pre_nclk", nclk, 1);
        clear_obs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        seg(1'b0, 10);
        expect_run("t5_idle", 0, 8'b0, 0, 6'd0);
        send(8, 2, 8'b01, 40);
        expect_run("t5", 2, 8'b01, 0, 6'd16);

        // back-to-back frames H=6 then H=12
        send(6, 2, 8'b10, 20);
        chk("t6a_pw", out_pulsewidth, 6'd12);
        send(12, 3, 8'b011, 60);
        expect_run("t6", 5, 8'b01110, 0, 6'd24);

        chk("clk_err_excl", nboth, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
